// File: rtl/multi_vc_input_buffer.sv
// Router input port: one circular FIFO per virtual channel, each sequenced by an
// IDLE -> VA -> SA packet FSM that drives allocator requests and error pulses.
package multi_vc_input_buffer_pkg;
  localparam int FLIT_VC_W   = 2;
  localparam int FLIT_DATA_W = 32;

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    EAST  = 3'd4
  } port_t;

  typedef struct packed {
    flit_label_t            flit_label;
    logic [FLIT_VC_W-1:0]   vc_id;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;
endpackage

module multi_vc_input_buffer
  import multi_vc_input_buffer_pkg::*;
#(
  parameter int VC_NUM      = 4,
  parameter int BUFFER_SIZE = 8,
  parameter int OFF_MARGIN  = 2,
  parameter int VC_SIZE     = $clog2(VC_NUM)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  flit_t                                       data_i,
  input  logic                                        valid_i,
  input  port_t                                       out_port_i,
  input  logic [VC_NUM-1:0]                           read_i,
  input  logic [VC_NUM-1:0]                           vc_valid_i,
  input  logic [VC_NUM-1:0][VC_SIZE-1:0]              vc_new_i,
  output flit_t [VC_NUM-1:0]                          data_o,
  output logic [VC_NUM-1:0]                           is_full_o,
  output logic [VC_NUM-1:0]                           is_empty_o,
  output logic [VC_NUM-1:0]                           on_off_o,
  output logic [VC_NUM-1:0][$clog2(BUFFER_SIZE+1)-1:0] occupancy_o,
  output port_t [VC_NUM-1:0]                          out_port_o,
  output logic [VC_NUM-1:0]                           vc_request_o,
  output logic [VC_NUM-1:0]                           switch_request_o,
  output logic [VC_NUM-1:0]                           vc_allocatable_o,
  output logic [VC_NUM-1:0][VC_SIZE-1:0]              downstream_vc_o,
  output logic [VC_NUM-1:0]                           error_o
);
  localparam int PTR_W = (BUFFER_SIZE > 1) ? $clog2(BUFFER_SIZE) : 1;
  localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VA   = 2'd1,
    SA   = 2'd2
  } state_t;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(BUFFER_SIZE - 1)) return {PTR_W{1'b0}};
    else return p + PTR_W'(1);
  endfunction

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    flit_t              mem_r [BUFFER_SIZE];
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]   count_r, count_s;
    state_t             state_r, state_s;
    port_t              out_port_r;
    logic [VC_SIZE-1:0] downstream_vc_r;
    logic               eop_r, eop_s, on_off_r, alloc_r, alloc_s, err_r, err_s;
    logic               push_s, pop_s, latch_port_s, latch_vc_s;
    logic               wr_s, empty_s, full_s, is_head_s, head_is_tail_s, body_ok_s;
    flit_t              head_s;

    assign wr_s           = valid_i && (data_i.vc_id == FLIT_VC_W'(v));
    assign empty_s        = (count_r == {CNT_W{1'b0}});
    assign full_s         = (count_r == CNT_W'(BUFFER_SIZE));
    assign is_head_s      = (data_i.flit_label == HEAD) || (data_i.flit_label == HEADTAIL);
    assign head_is_tail_s = (mem_r[rd_ptr_r].flit_label == TAIL) ||
                            (mem_r[rd_ptr_r].flit_label == HEADTAIL);
    // Continuation flits are legal only until the tail of the current packet.
    assign body_ok_s      = wr_s && !is_head_s && !eop_r && !full_s;

    // Per-VC packet FSM: decides push/pop, latches and the error/allocatable pulses.
    always_comb begin
      state_s      = state_r;
      eop_s        = eop_r;
      push_s       = 1'b0;
      pop_s        = 1'b0;
      latch_port_s = 1'b0;
      latch_vc_s   = 1'b0;
      alloc_s      = 1'b0;
      err_s        = 1'b0;
      case (state_r)
        IDLE: begin
          if (wr_s && is_head_s && empty_s) begin
            push_s       = 1'b1;
            latch_port_s = 1'b1;
            eop_s        = (data_i.flit_label == HEADTAIL);
            state_s      = VA;
          end else begin
            err_s = wr_s;
          end
          err_s = err_s | vc_valid_i[v] | read_i[v];
        end
        VA: begin
          push_s = body_ok_s;
          eop_s  = eop_r | (body_ok_s && (data_i.flit_label == TAIL));
          err_s  = (wr_s && !body_ok_s) | read_i[v];
          if (vc_valid_i[v]) begin
            latch_vc_s = 1'b1;
            state_s    = SA;
          end else begin
            state_s = VA;
          end
        end
        SA: begin
          push_s = body_ok_s;
          eop_s  = eop_r | (body_ok_s && (data_i.flit_label == TAIL));
          pop_s  = read_i[v] && !empty_s;
          err_s  = (wr_s && !body_ok_s) | vc_valid_i[v] | (read_i[v] && empty_s);
          if (pop_s && head_is_tail_s) begin
            state_s = IDLE;
            alloc_s = 1'b1;
            eop_s   = 1'b0;
          end else begin
            state_s = SA;
          end
        end
        default: begin
          state_s = IDLE;
          eop_s   = 1'b0;
          alloc_s = 1'b1;
          err_s   = 1'b1;
        end
      endcase
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CNT_W'(1);
        2'b01:   count_s = count_r - CNT_W'(1);
        default: count_s = count_r;
      endcase
    end

    // Flit storage; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= data_i;
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_r         <= IDLE;
        rd_ptr_r        <= {PTR_W{1'b0}};
        wr_ptr_r        <= {PTR_W{1'b0}};
        count_r         <= {CNT_W{1'b0}};
        eop_r           <= 1'b0;
        on_off_r        <= 1'b1;
        alloc_r         <= 1'b0;
        err_r           <= 1'b0;
        out_port_r      <= LOCAL;
        downstream_vc_r <= {VC_SIZE{1'b0}};
      end else begin
        state_r  <= state_s;
        eop_r    <= eop_s;
        count_r  <= count_s;
        on_off_r <= (BUFFER_SIZE - int'(count_s)) > OFF_MARGIN;
        alloc_r  <= alloc_s;
        err_r    <= err_s;
        if (push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
        if (latch_port_s) out_port_r <= out_port_i;
        if (latch_vc_s) downstream_vc_r <= vc_new_i[v];
      end
    end

    // Head flit leaves with the downstream VC substituted.
    always_comb begin
      head_s       = mem_r[rd_ptr_r];
      head_s.vc_id = FLIT_VC_W'(downstream_vc_r);
    end

    assign data_o[v]           = head_s;
    assign is_full_o[v]        = full_s;
    assign is_empty_o[v]       = empty_s;
    assign on_off_o[v]         = on_off_r;
    assign occupancy_o[v]      = count_r;
    assign out_port_o[v]       = out_port_r;
    assign vc_request_o[v]     = (state_r == VA);
    assign switch_request_o[v] = (state_r == SA) && !empty_s;
    assign vc_allocatable_o[v] = alloc_r;
    assign downstream_vc_o[v]  = downstream_vc_r;
    assign error_o[v]          = err_r;
  end
endmodule

// File: tb/tb_multi_vc_input_buffer.sv
// Self-checking bench for multi_vc_input_buffer: vector table plus hand-written
// sequences, with per-VC scoreboard queues checking the FIFO head on every read.
module tb_multi_vc_input_buffer;
  import multi_vc_input_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  flit_t data_i;
  logic valid_i;
  port_t out_port_i;
  logic [3:0] read_i, vc_valid_i;
  logic [3:0][1:0] vc_new_i;
  flit_t [3:0] data_o;
  logic [3:0] is_full_o, is_empty_o, on_off_o;
  logic [3:0][3:0] occupancy_o;
  port_t [3:0] out_port_o;
  logic [3:0] vc_request_o, switch_request_o, vc_allocatable_o, error_o;
  logic [3:0][1:0] downstream_vc_o;

  multi_vc_input_buffer #(.VC_NUM(4), .BUFFER_SIZE(8), .OFF_MARGIN(2), .VC_SIZE(2)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .out_port_i(out_port_i),
    .read_i(read_i), .vc_valid_i(vc_valid_i), .vc_new_i(vc_new_i), .data_o(data_o),
    .is_full_o(is_full_o), .is_empty_o(is_empty_o), .on_off_o(on_off_o),
    .occupancy_o(occupancy_o), .out_port_o(out_port_o), .vc_request_o(vc_request_o),
    .switch_request_o(switch_request_o), .vc_allocatable_o(vc_allocatable_o),
    .downstream_vc_o(downstream_vc_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  flit_t exp_q [4][$];
  logic [31:0] seq_data = 32'h1000;

  typedef struct {
    logic wv; flit_label_t lbl; logic [1:0] vc; port_t port; logic acc;
    logic [3:0] rd, rbad, vcv; logic [1:0] vnew, hvc, cvc;
    logic [3:0] occ; logic vreq, sreq, alloc; logic [3:0] err; port_t eport;
  } vec_t;
  vec_t tbl [22];

  function automatic vec_t mk(input logic wv, input flit_label_t lbl, input logic [1:0] vc,
      input port_t port, input logic acc, input logic [3:0] rd, input logic [3:0] rbad,
      input logic [3:0] vcv, input logic [1:0] vnew, input logic [1:0] hvc,
      input logic [1:0] cvc, input logic [3:0] occ, input logic vreq, input logic sreq,
      input logic alloc, input logic [3:0] err, input port_t eport);
    vec_t r;
    r.wv = wv; r.lbl = lbl; r.vc = vc; r.port = port; r.acc = acc; r.rd = rd; r.rbad = rbad;
    r.vcv = vcv; r.vnew = vnew; r.hvc = hvc; r.cvc = cvc; r.occ = occ; r.vreq = vreq;
    r.sreq = sreq; r.alloc = alloc; r.err = err; r.eport = eport;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; read_i = 4'h0; vc_valid_i = 4'h0; data_i = '0;
    out_port_i = LOCAL; vc_new_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] vc, input flit_label_t lbl, input port_t p, input logic acc);
    flit_t f;
    f.flit_label = lbl; f.vc_id = vc; f.data = seq_data;
    seq_data = seq_data + 32'd1;
    data_i = f; valid_i = 1'b1; out_port_i = p;
    if (acc) exp_q[vc].push_back(f);
  endtask

  // Compares the current head against the scoreboard and requests the pop.
  task automatic pop_check(input int vc, input logic [1:0] hvc);
    flit_t e;
    if (exp_q[vc].size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL sb_underflow vc%0d: got read with no expected flit, required one queued", vc);
    end else begin
      e = exp_q[vc].pop_front();
      e.vc_id = hvc;
      chk($sformatf("data_o[%0d]", vc), 64'(data_o[vc]), 64'(e));
    end
    read_i[vc] = 1'b1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, 64'(is_empty_o), 64'h0F);
    chk({tag, "_full"}, 64'(is_full_o), 64'h0);
    chk({tag, "_occ"}, 64'(occupancy_o), 64'h0);
    chk({tag, "_onoff"}, 64'(on_off_o), 64'h0F);
    chk({tag, "_port"}, 64'(out_port_o), 64'h0);
    chk({tag, "_dvc"}, 64'(downstream_vc_o), 64'h0);
    chk({tag, "_req"}, 64'({vc_request_o, switch_request_o, vc_allocatable_o, error_o}), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          wv lbl       vc port  acc rd    rbad  vcv   vn hvc cvc occ vr sr al err   eport
    tbl[0]  = mk(1, HEAD,     1, NORTH, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 1, 1, 0, 0, 4'h0, NORTH);
    tbl[1]  = mk(1, BODY,     1, LOCAL, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 2, 1, 0, 0, 4'h0, NORTH);
    tbl[2]  = mk(1, TAIL,     1, LOCAL, 1, 4'h0, 4'h0, 4'h0, 0, 0, 1, 3, 1, 0, 0, 4'h0, NORTH);
    tbl[3]  = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h2, 3, 0, 1, 3, 0, 1, 0, 4'h0, NORTH);
    tbl[4]  = mk(0, BODY,     0, LOCAL, 0, 4'h2, 4'h0, 4'h0, 0, 3, 1, 2, 0, 1, 0, 4'h0, NORTH);
    tbl[5]  = mk(0, BODY,     0, LOCAL, 0, 4'h2, 4'h0, 4'h0, 0, 3, 1, 1, 0, 1, 0, 4'h0, NORTH);
    tbl[6]  = mk(0, BODY,     0, LOCAL, 0, 4'h2, 4'h0, 4'h0, 0, 3, 1, 0, 0, 0, 1, 4'h0, NORTH);
    tbl[7]  = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0, 4'h0, NORTH);
    tbl[8]  = mk(1, HEADTAIL, 0, EAST,  1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 1, 0, 0, 4'h0, EAST);
    tbl[9]  = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h1, 2, 0, 0, 1, 0, 1, 0, 4'h0, EAST);
    tbl[10] = mk(0, BODY,     0, LOCAL, 0, 4'h1, 4'h0, 4'h0, 0, 2, 0, 0, 0, 0, 1, 4'h0, EAST);
    tbl[11] = mk(1, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h1, EAST);
    tbl[12] = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h0, EAST);
    tbl[13] = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 0, 0, 4'h1, EAST);
    tbl[14] = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h4, 0, 0, 2, 0, 0, 0, 0, 4'h4, LOCAL);
    tbl[15] = mk(1, HEAD,     2, WEST,  1, 4'h0, 4'h0, 4'h0, 0, 0, 2, 1, 1, 0, 0, 4'h0, WEST);
    tbl[16] = mk(1, HEAD,     2, SOUTH, 0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 1, 1, 0, 0, 4'h4, WEST);
    tbl[17] = mk(1, TAIL,     2, LOCAL, 1, 4'h0, 4'h0, 4'h0, 0, 0, 2, 2, 1, 0, 0, 4'h0, WEST);
    tbl[18] = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h4, 1, 0, 2, 2, 0, 1, 0, 4'h0, WEST);
    tbl[19] = mk(0, BODY,     0, LOCAL, 0, 4'h4, 4'h0, 4'h0, 0, 1, 2, 1, 0, 1, 0, 4'h0, WEST);
    tbl[20] = mk(0, BODY,     0, LOCAL, 0, 4'h4, 4'h0, 4'h0, 0, 1, 2, 0, 0, 0, 1, 4'h0, WEST);
    tbl[21] = mk(0, BODY,     0, LOCAL, 0, 4'h0, 4'h0, 4'h0, 0, 0, 2, 0, 0, 0, 0, 4'h0, WEST);

    rst = 1'b1;
    drive_idle();
    #2;
    chk_reset_state("reset");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // Table: single-VC packets, grants, reads and protocol errors.
    for (int i = 0; i < 22; i++) begin
      drive_idle();
      if (tbl[i].wv) send(tbl[i].vc, tbl[i].lbl, tbl[i].port, tbl[i].acc);
      for (int k = 0; k < 4; k++) if (tbl[i].rd[k]) pop_check(k, tbl[i].hvc);
      read_i = read_i | tbl[i].rbad;
      vc_valid_i = tbl[i].vcv;
      vc_new_i = {4{tbl[i].vnew}};
      tick();
      chk($sformatf("r%0d_occ", i), 64'(occupancy_o[tbl[i].cvc]), 64'(tbl[i].occ));
      chk($sformatf("r%0d_vreq", i), 64'(vc_request_o[tbl[i].cvc]), 64'(tbl[i].vreq));
      chk($sformatf("r%0d_sreq", i), 64'(switch_request_o[tbl[i].cvc]), 64'(tbl[i].sreq));
      chk($sformatf("r%0d_alloc", i), 64'(vc_allocatable_o[tbl[i].cvc]), 64'(tbl[i].alloc));
      chk($sformatf("r%0d_err", i), 64'(error_o), 64'(tbl[i].err));
      chk($sformatf("r%0d_port", i), 64'(out_port_o[tbl[i].cvc]), 64'(tbl[i].eport));
    end

    // Interleaved packets on vc0 and vc2.
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      send((c % 2 == 0) ? 2'd0 : 2'd2, (c < 2) ? HEAD : ((c < 4) ? BODY : TAIL),
           (c % 2 == 0) ? NORTH : SOUTH, 1'b1);
      tick();
    end
    drive_idle();
    vc_valid_i = 4'b0101;
    vc_new_i[0] = 2'd1;
    vc_new_i[2] = 2'd3;
    tick();
    chk("il_occ", 64'(occupancy_o), 64'h0303);
    chk("il_port0", 64'(out_port_o[0]), 64'(NORTH));
    chk("il_port2", 64'(out_port_o[2]), 64'(SOUTH));
    chk("il_sreq", 64'(switch_request_o), 64'h5);
    for (int r = 0; r < 3; r++) begin
      drive_idle();
      pop_check(0, 2'd1);
      pop_check(2, 2'd3);
      tick();
      chk($sformatf("il_alloc%0d", r), 64'(vc_allocatable_o), (r == 2) ? 64'h5 : 64'h0);
    end
    drive_idle();
    tick();
    chk("il_err", 64'(error_o), 64'h0);
    for (int k = 0; k < 3; k++) chk($sformatf("sb_left%0d", k), 64'(exp_q[k].size()), 64'h0);

    // Fill vc3 to full, overflow, then drain half in SA.
    for (int n = 1; n <= 9; n++) begin
      drive_idle();
      send(2'd3, (n == 1) ? HEAD : BODY, WEST, n <= 8);
      tick();
      chk($sformatf("fill%0d_occ", n), 64'(occupancy_o[3]), (n <= 8) ? 64'(n) : 64'd8);
      chk($sformatf("fill%0d_onoff", n), 64'(on_off_o[3]), ((8 - ((n <= 8) ? n : 8)) > 2) ? 64'h1 : 64'h0);
      chk($sformatf("fill%0d_full", n), 64'(is_full_o[3]), (n >= 8) ? 64'h1 : 64'h0);
      chk($sformatf("fill%0d_err", n), 64'(error_o), (n == 9) ? 64'h8 : 64'h0);
    end
    drive_idle();
    vc_valid_i = 4'b1000;
    vc_new_i[3] = 2'd2;
    tick();
    chk("fill_sreq", 64'(switch_request_o), 64'h8);
    chk("fill_dvc", 64'(downstream_vc_o[3]), 64'h2);
    chk("fill_err", 64'(error_o), 64'h0);
    for (int r = 0; r < 4; r++) begin
      drive_idle();
      pop_check(3, 2'd2);
      tick();
      chk($sformatf("drain%0d_occ", r), 64'(occupancy_o[3]), 64'(7 - r));
      chk($sformatf("drain%0d_onoff", r), 64'(on_off_o[3]), (r >= 2) ? 64'h1 : 64'h0);
    end

    // Asynchronous reset mid-packet, checked before any clock edge.
    drive_idle();
    #2 rst = 1'b1;
    #1;
    chk_reset_state("arst");
    exp_q[3].delete();
    tick();
    #2 rst = 1'b0;
    tick();
    chk_reset_state("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
